apb_master_bridge: RTL

// - APB3 requester: turns a simple valid/ready command stream into APB SETUP/ACCESS transfers toward apb_slave.
// - Returns read data and error on a registered response port; one transfer outstanding at a time.
// - Bounds wait states with a timeout, so a hung slave cannot stall the command source forever.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_wait_timer.sv | 43 ++++
 rtl/apb_master_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH     = 32;
  localparam int unsigned APB_DATA_WIDTH     = 32;
  localparam int unsigned APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase; flags expiry after TIMEOUT_CYCLES stalled cycles.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign expired_c = 1'b0;
  end else begin : g_on
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at LIMIT so the expiry flag cannot wrap away.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && (cnt_q != LIMIT)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge PCLK) begin
      if (PRESET) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired_c = (cnt_q == LIMIT);
  end

endmodule : apb_wait_timer

// File: rtl/apb_master_bridge.sv
// APB3 requester: valid/ready command in, SETUP/ACCESS transfer out, registered response back.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e            state_q,     state_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  timer_expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .clear     (state_q == APB_SETUP),
    .enable    ((state_q == APB_ACCESS) && !PREADY),
    .expired_c (timer_expired)
  );

  // Only accept when idle and the response slot is free (or being freed this edge).
  assign cmd_ready = (state_q == APB_IDLE) && (!rsp_valid_q || rsp_ready);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      APB_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          state_d  = APB_SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      APB_SETUP: begin
        state_d   = APB_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      APB_ACCESS: begin
        // A ready slave beats a simultaneous timer expiry.
        if (PREADY) begin
          state_d     = APB_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (timer_expired) begin
          state_d     = APB_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d   = APB_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= APB_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule : apb_master_bridge
